mem_wb_skid_stage: RTL and testbench

Parametrised MEM/WB pipeline stage register with a two-entry skid buffer, valid/ready handshake, synchronous flush, bubble tagging and a registered forwarding view for the hazard unit. It sits between the memory stage and the write-back stage. It replaces fixed-width, free-running stage latching with back-pressure-safe buffering, so a stalled write-back never drops or duplicates an instruction. All payload fields are carried in strict FIFO order.

---
 rtl/mem_wb_skid_stage.sv | 139 +++++++++++++
 tb/tb_mem_wb_skid_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage
//
// MEM/WB pipeline stage register with a two-entry skid buffer. It sits
// between the memory stage and write-back. A stalled write-back never drops
// or duplicates an instruction, and entries always leave in arrival order.
//
// Handshake: a transfer happens on a rising edge when valid and ready are
// both high on that side (accept = in_valid & in_ready, drain = out_valid &
// out_ready). in_ready and out_valid come from registered state only, so
// in_ready never depends on out_ready and no input reaches an output
// combinationally. Once offered, an upstream entry is held stable until it
// is accepted.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               synchronous clear of both entries (highest priority)
//   in_valid/in_ready   upstream handshake
//   in_bubble, in_ctrl, in_dest, in_res, in_mem   upstream entry fields
//   out_valid/out_ready downstream handshake
//   out_bubble, out_ctrl, out_dest, out_res, out_mem  head entry fields
//   fwd_valid/dest/data registered forwarding view of the head entry
//   occupancy           entries held (0..2); also the FSM state view
//
// Control bundle: bit0 = RegWrite, bit1 = MemOrReg (1 selects memory data),
// bit2 = DestOrPrivate, any higher bits are carried through untouched.

module mem_wb_skid_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bubble,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0] in_res,
  input  logic [DATA_W-1:0] in_mem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bubble,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_res,
  output logic [DATA_W-1:0] out_mem,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              bubble;
    logic [CTRL_W-1:0] ctrl;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] mem;
  } entryT;

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stateT;

  stateT state;
  entryT headSlot;
  entryT skidSlot;
  entryT inEntry;
  logic  accept;
  logic  drain;

  assign inEntry = '{bubble: in_bubble, ctrl: in_ctrl, dest: in_dest,
                     res: in_res, mem: in_mem};

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Payload slots are written only on load; empty slots keep stale data,
  // which is harmless because out_valid/fwd_valid are low then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      headSlot <= '0;
      skidSlot <= '0;
    end else if (flush) begin
      // Any entry offered at this edge is discarded; a drain at this edge
      // has already been taken by write-back, so nothing else to undo.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            headSlot <= inEntry;
            state    <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            headSlot <= inEntry;
          end else if (accept) begin
            skidSlot <= inEntry;
            state    <= TWO;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            headSlot <= skidSlot;
            state    <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_bubble = headSlot.bubble;
  assign out_ctrl   = headSlot.ctrl;
  assign out_dest   = headSlot.dest;
  assign out_res    = headSlot.res;
  assign out_mem    = headSlot.mem;

  // Forwarding view: only a real (non-bubble) RegWrite head is advertised.
  assign fwd_valid = out_valid & ~headSlot.bubble & headSlot.ctrl[0];
  assign fwd_dest  = headSlot.dest;
  assign fwd_data  = headSlot.ctrl[1] ? headSlot.mem : headSlot.res;

  assign occupancy = state;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed testbench for mem_wb_skid_stage. Inputs are driven and outputs
// sampled 1 time unit after each rising clock edge.

module tb_mem_wb_skid_stage;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int CTRL_W = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_bubble = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [ADDR_W-1:0] in_dest = '0;
  logic [DATA_W-1:0] in_res = '0;
  logic [DATA_W-1:0] in_mem = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_bubble;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ADDR_W-1:0] out_dest;
  logic [DATA_W-1:0] out_res;
  logic [DATA_W-1:0] out_mem;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_dest;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        occupancy;

  mem_wb_skid_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
    .in_ctrl(in_ctrl), .in_dest(in_dest), .in_res(in_res), .in_mem(in_mem),
    .out_valid(out_valid), .out_ready(out_ready), .out_bubble(out_bubble),
    .out_ctrl(out_ctrl), .out_dest(out_dest), .out_res(out_res),
    .out_mem(out_mem), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_data(fwd_data), .occupancy(occupancy)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic [CTRL_W-1:0] c,
                       input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] r,
                       input logic [DATA_W-1:0] m);
    in_valid  = v;
    in_bubble = b;
    in_ctrl   = c;
    in_dest   = d;
    in_res    = r;
    in_mem    = m;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #1;
    check_eq("rst_occ",   32'(occupancy), 0);
    check_eq("rst_rdy",   32'(in_ready), 1);
    check_eq("rst_ovld",  32'(out_valid), 0);
    check_eq("rst_fwd",   32'(fwd_valid), 0);
    check_eq("rst_res",   32'(out_res), 0);
    check_eq("rst_mem",   32'(out_mem), 0);
    check_eq("rst_ctrl",  32'(out_ctrl), 0);
    tick();
    rst = 1'b0;

    // Stream 1..8 with out_ready high: one per cycle, occupancy stays 1
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 3'b001, 4'(i), 16'(i), 16'h0);
      if (i == 1) check_eq("no_bypass", 32'(out_valid), 0);
      tick();
      check_eq($sformatf("strm_res%0d", i), 32'(out_res), i);
      check_eq($sformatf("strm_occ%0d", i), 32'(occupancy), 1);
      check_eq($sformatf("strm_rdy%0d", i), 32'(in_ready), 1);
    end
    idle();
    tick();
    check_eq("strm_empty", 32'(occupancy), 0);

    // Back-pressure: three edges with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b001, 4'd1, 16'h0011, 16'h0);
    tick();
    check_eq("bp_occ1", 32'(occupancy), 1);
    check_eq("bp_rdy1", 32'(in_ready), 1);
    check_eq("bp_res1", 32'(out_res), 32'h11);
    drive(1'b1, 1'b0, 3'b001, 4'd2, 16'h0012, 16'h0);
    tick();
    check_eq("bp_occ2", 32'(occupancy), 2);
    check_eq("bp_rdy2", 32'(in_ready), 0);
    check_eq("bp_res2", 32'(out_res), 32'h11);
    drive(1'b1, 1'b0, 3'b001, 4'd3, 16'h0013, 16'h0);
    tick();
    check_eq("bp_occ3", 32'(occupancy), 2);
    check_eq("bp_res3", 32'(out_res), 32'h11);
    idle();
    out_ready = 1'b1;
    tick();
    check_eq("bp_dr_res", 32'(out_res), 32'h12);
    check_eq("bp_dr_occ", 32'(occupancy), 1);
    check_eq("bp_dr_rdy", 32'(in_ready), 1);
    tick();
    check_eq("bp_dr_vld", 32'(out_valid), 0);

    // Forwarding view: memory select then ALU select
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b011, 4'd5, 16'h1234, 16'hBEEF);
    tick();
    check_eq("fwd_vld_m",  32'(fwd_valid), 1);
    check_eq("fwd_dst_m",  32'(fwd_dest), 5);
    check_eq("fwd_dat_m",  32'(fwd_data), 32'hBEEF);
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 4'd5, 16'h1234, 16'hBEEF);
    tick();
    check_eq("fwd_vld_r",  32'(fwd_valid), 1);
    check_eq("fwd_dat_r",  32'(fwd_data), 32'h1234);
    idle();
    tick();
    check_eq("fwd_off",    32'(fwd_valid), 0);

    // Bubble with RegWrite set, followed by a real entry
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 3'b001, 4'd7, 16'hAAAA, 16'h0);
    tick();
    check_eq("bub_vld",   32'(out_valid), 1);
    check_eq("bub_flag",  32'(out_bubble), 1);
    check_eq("bub_fwd",   32'(fwd_valid), 0);
    check_eq("bub_ctrl",  32'(out_ctrl), 1);
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 4'd8, 16'h5555, 16'h0);
    tick();
    check_eq("aft_flag",  32'(out_bubble), 0);
    check_eq("aft_fwd",   32'(fwd_valid), 1);
    check_eq("aft_res",   32'(out_res), 32'h5555);
    check_eq("aft_dst",   32'(fwd_dest), 8);
    idle();
    tick();

    // Flush while full with an entry offered at the same edge
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b001, 4'd1, 16'h0021, 16'h0);
    tick();
    drive(1'b1, 1'b0, 3'b001, 4'd2, 16'h0022, 16'h0);
    tick();
    check_eq("fl_pre_occ", 32'(occupancy), 2);
    flush = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 4'd3, 16'h0023, 16'h0);
    tick();
    flush = 1'b0;
    idle();
    check_eq("fl_occ",  32'(occupancy), 0);
    check_eq("fl_vld",  32'(out_valid), 0);
    check_eq("fl_rdy",  32'(in_ready), 1);
    check_eq("fl_fwd",  32'(fwd_valid), 0);
    out_ready = 1'b1;
    tick();
    check_eq("fl_stay", 32'(out_valid), 0);
    drive(1'b1, 1'b0, 3'b001, 4'd4, 16'h0030, 16'h0);
    tick();
    check_eq("fl_next", 32'(out_res), 32'h30);
    idle();
    tick();

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 3'b011, 4'd9, 16'h0041, 16'h0F41);
    tick();
    drive(1'b1, 1'b0, 3'b011, 4'd9, 16'h0042, 16'h0F42);
    tick();
    check_eq("ar_pre_occ", 32'(occupancy), 2);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_occ",  32'(occupancy), 0);
    check_eq("ar_vld",  32'(out_valid), 0);
    check_eq("ar_rdy",  32'(in_ready), 1);
    check_eq("ar_fwd",  32'(fwd_valid), 0);
    check_eq("ar_res",  32'(out_res), 0);
    check_eq("ar_mem",  32'(out_mem), 0);
    check_eq("ar_dst",  32'(out_dest), 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 3'b001, 4'd2, 16'h0050, 16'h0);
    tick();
    check_eq("ar_rest_res", 32'(out_res), 32'h50);
    check_eq("ar_rest_occ", 32'(occupancy), 1);
    idle();
    tick();
    check_eq("ar_end", 32'(out_valid), 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
